fc_layer_param: RTL and testbench

//  Parametrised fully-connected layer engine; generalises the fixed single-pass FC layer to any IN_NEURON/OUT_NEURON/PI/PO.

---
 rtl/fc_layer_param.sv | 165 ++++++++++++++++
 tb/tb_fc_layer_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_param.sv
// fc_layer_param: streaming fully-connected layer, PI inputs x PO outputs per beat, signed MAC + rescale + saturate.
// Optional build macro FC_RELU_EN: negative output lanes are written as zero after saturation.
module fc_layer_param #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 40,
  parameter int FRAC_BITS   = 8,
  parameter int IN_NEURON   = 64,
  parameter int OUT_NEURON  = 16,
  parameter int PI          = 4,
  parameter int PO          = 2,
  localparam int BEATS  = IN_NEURON / PI,
  localparam int GROUPS = OUT_NEURON / PO,
  localparam int IN_AW  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int W_AW   = (BEATS * GROUPS > 1) ? $clog2(BEATS * GROUPS) : 1,
  localparam int OUT_AW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       in_rden,
  output logic [IN_AW-1:0]           in_addr,
  input  logic [DATA_WIDTH*PI-1:0]   in_q,
  output logic                       w_rden,
  output logic [W_AW-1:0]            w_addr,
  input  logic [DATA_WIDTH*PI*PO-1:0] w_q,
  output logic                       out_wren,
  output logic [OUT_AW-1:0]          out_addr,
  output logic [DATA_WIDTH*PO-1:0]   out_data
);

  if (IN_NEURON % PI != 0) begin : g_bad_pi
    $error("IN_NEURON must be a multiple of PI");
  end
  if (OUT_NEURON % PO != 0) begin : g_bad_po
    $error("OUT_NEURON must be a multiple of PO");
  end

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_READ  | issuing one beat per cycle to both RAMs
  // S_FLUSH | absorbing the final beat's data
  // S_WRITE | storing the saturated group word
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_WRITE, S_DONE} state_t;

  localparam logic [IN_AW-1:0]  LAST_BEAT  = IN_AW'(BEATS - 1);
  localparam logic [OUT_AW-1:0] LAST_GROUP = OUT_AW'(GROUPS - 1);
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX =
    ACCUM_WIDTH'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t state, state_nxt;
  logic [IN_AW-1:0]  beat;
  logic [W_AW-1:0]   waddr;
  logic [OUT_AW-1:0] group;
  logic              last_beat, last_group;
  logic              vld, vld_first;
  logic signed [2*DATA_WIDTH-1:0] prod [PO][PI];
  logic signed [ACCUM_WIDTH-1:0]  sum [PO];
  logic signed [ACCUM_WIDTH-1:0]  acc [PO];
  logic signed [ACCUM_WIDTH-1:0]  shifted [PO];
  logic signed [DATA_WIDTH-1:0]   lane [PO];

  assign last_beat  = (beat == LAST_BEAT);
  assign last_group = (group == LAST_GROUP);
  assign in_addr    = beat;
  assign w_addr     = waddr;
  assign out_addr   = group;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (last_beat) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_group ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_rden  = 1'b0;
    w_rden   = 1'b0;
    out_wren = 1'b0;
    case (state)
      S_READ:  begin busy = 1'b1; in_rden = 1'b1; w_rden = 1'b1; end
      S_FLUSH: busy = 1'b1;
      S_WRITE: begin busy = 1'b1; out_wren = 1'b1; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Weight address runs linearly across groups, so it only needs clearing after the last group.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beat  <= '0;
      waddr <= '0;
      group <= '0;
    end else begin
      if (state == S_READ) begin
        beat  <= last_beat ? '0 : beat + IN_AW'(1);
        waddr <= waddr + W_AW'(1);
      end
      if (state == S_WRITE) begin
        group <= last_group ? '0 : group + OUT_AW'(1);
        if (last_group) waddr <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld       <= 1'b0;
      vld_first <= 1'b0;
    end else begin
      vld       <= (state == S_READ);
      vld_first <= (state == S_READ) && (beat == '0);
    end
  end

  always_comb begin
    for (int o = 0; o < PO; o++) begin
      sum[o] = '0;
      for (int i = 0; i < PI; i++) begin
        prod[o][i] = $signed(in_q[i*DATA_WIDTH +: DATA_WIDTH]) *
                     $signed(w_q[(o*PI+i)*DATA_WIDTH +: DATA_WIDTH]);
        sum[o] = sum[o] + ACCUM_WIDTH'(prod[o][i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int o = 0; o < PO; o++) acc[o] <= '0;
    end else if (vld) begin
      for (int o = 0; o < PO; o++) acc[o] <= vld_first ? sum[o] : acc[o] + sum[o];
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < PO; o++) begin
      shifted[o] = acc[o] >>> FRAC_BITS;
      if (shifted[o] > SAT_MAX)      lane[o] = SAT_MAX[DATA_WIDTH-1:0];
      else if (shifted[o] < SAT_MIN) lane[o] = SAT_MIN[DATA_WIDTH-1:0];
      else                           lane[o] = shifted[o][DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
      if (lane[o][DATA_WIDTH-1]) lane[o] = '0;
`endif
      out_data[o*DATA_WIDTH +: DATA_WIDTH] = lane[o];
    end
  end

endmodule

// File: tb/tb_fc_layer_param.sv
// Bench for fc_layer_param: a default-size engine and a single-beat engine, checked against a dot-product model.
`timescale 1ns/1ps
module tb_fc_layer_param;
  localparam int DW = 16, PI = 4, PO = 2;
  localparam int B_IN = 64, B_OUT = 16, B_FRAC = 8, B_BEATS = 16, B_GROUPS = 8;
  localparam int S_IN = 4, S_OUT = 2, S_FRAC = 0;

  logic clk = 1'b0, reset = 1'b0, start_b = 1'b0, start_s = 1'b0;
  always #5 clk = ~clk;

  logic busy_b, done_b, in_rden_b, w_rden_b, out_wren_b;
  logic [3:0] in_addr_b; logic [6:0] w_addr_b; logic [2:0] out_addr_b;
  logic [DW*PI-1:0] in_q_b = '0; logic [DW*PI*PO-1:0] w_q_b = '0; logic [DW*PO-1:0] out_data_b;
  logic busy_s, done_s, in_rden_s, w_rden_s, out_wren_s;
  logic [0:0] in_addr_s, w_addr_s, out_addr_s;
  logic [DW*PI-1:0] in_q_s = '0; logic [DW*PI*PO-1:0] w_q_s = '0; logic [DW*PO-1:0] out_data_s;

  fc_layer_param dut_b (
    .clock(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .in_rden(in_rden_b), .in_addr(in_addr_b), .in_q(in_q_b),
    .w_rden(w_rden_b), .w_addr(w_addr_b), .w_q(w_q_b),
    .out_wren(out_wren_b), .out_addr(out_addr_b), .out_data(out_data_b));

  fc_layer_param #(.IN_NEURON(S_IN), .OUT_NEURON(S_OUT), .FRAC_BITS(S_FRAC)) dut_s (
    .clock(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
    .in_rden(in_rden_s), .in_addr(in_addr_s), .in_q(in_q_s),
    .w_rden(w_rden_s), .w_addr(w_addr_s), .w_q(w_q_s),
    .out_wren(out_wren_s), .out_addr(out_addr_s), .out_data(out_data_s));

  shortint b_in[B_IN];
  shortint b_w[B_OUT][B_IN];
  shortint s_in[S_IN];
  shortint s_w[S_OUT][S_IN];

  function automatic logic [DW*PI-1:0] pack_in_b(int b);
    logic [DW*PI-1:0] r = '0;
    for (int i = 0; i < PI; i++) r[i*DW +: DW] = b_in[b*PI+i];
    return r;
  endfunction

  function automatic logic [DW*PI*PO-1:0] pack_w_b(int a);
    logic [DW*PI*PO-1:0] r = '0;
    int g = a / B_BEATS, b = a % B_BEATS;
    for (int o = 0; o < PO; o++)
      for (int i = 0; i < PI; i++) r[(o*PI+i)*DW +: DW] = b_w[g*PO+o][b*PI+i];
    return r;
  endfunction

  function automatic logic [DW*PI*PO-1:0] pack_w_s();
    logic [DW*PI*PO-1:0] r = '0;
    for (int o = 0; o < PO; o++)
      for (int i = 0; i < PI; i++) r[(o*PI+i)*DW +: DW] = s_w[o][i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (in_rden_b) in_q_b <= pack_in_b(int'(in_addr_b));
    if (w_rden_b)  w_q_b  <= pack_w_b(int'(w_addr_b));
    if (in_rden_s) in_q_s <= {s_in[3], s_in[2], s_in[1], s_in[0]};
    if (w_rden_s)  w_q_s  <= pack_w_s();
  end

  function automatic logic [DW-1:0] sat_lane(longint a, int frac);
    longint v = a >>> frac;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`ifdef FC_RELU_EN
    if (v < 0) v = 0;
`endif
    return DW'(v);
  endfunction

  function automatic logic [DW*PO-1:0] exp_b(int g);
    logic [DW*PO-1:0] r = '0;
    longint a;
    for (int o = 0; o < PO; o++) begin
      a = 0;
      for (int n = 0; n < B_IN; n++) a += longint'(b_in[n]) * longint'(b_w[g*PO+o][n]);
      r[o*DW +: DW] = sat_lane(a, B_FRAC);
    end
    return r;
  endfunction

  function automatic logic [DW*PO-1:0] exp_s();
    logic [DW*PO-1:0] r = '0;
    longint a;
    for (int o = 0; o < PO; o++) begin
      a = 0;
      for (int n = 0; n < S_IN; n++) a += longint'(s_in[n]) * longint'(s_w[o][n]);
      r[o*DW +: DW] = sat_lane(a, S_FRAC);
    end
    return r;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa_q[$], wc_q[$], sa_q[$], sc_q[$];
  logic [DW*PO-1:0] wd_q[$], sd_q[$];
  always @(negedge clk) begin
    if (out_wren_b) begin wa_q.push_back(int'(out_addr_b)); wd_q.push_back(out_data_b); wc_q.push_back(cyc); end
    if (out_wren_s) begin sa_q.push_back(int'(out_addr_s)); sd_q.push_back(out_data_s); sc_q.push_back(cyc); end
  end

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic go(input bit big, output int s0);
    @(negedge clk);
    if (big) start_b = 1'b1; else start_s = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; start_s = 1'b0;
    s0 = cyc;
  endtask

  task automatic wait_done(input bit big, input string tag, output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (big ? done_b : done_s) begin d = cyc; break; end
    end
    chk({tag, " done_seen"}, d != -1, 1);
  endtask

  task automatic check_pass_b(input string tag, input int s0, input int d);
    chk({tag, " done_cyc"}, d, s0 + B_GROUPS*(B_BEATS+2));
    chk({tag, " n_writes"}, wa_q.size(), B_GROUPS);
    for (int g = 0; g < B_GROUPS && g < wa_q.size(); g++) begin
      chk($sformatf("%s addr[%0d]", tag, g), wa_q[g], g);
      chk($sformatf("%s data[%0d]", tag, g), wd_q[g], exp_b(g));
      chk($sformatf("%s wcyc[%0d]", tag, g), wc_q[g], s0 + g*(B_BEATS+2) + B_BEATS + 1);
    end
  endtask

  task automatic check_pass_s(input string tag, input int s0, input int d);
    chk({tag, " done_cyc"}, d, s0 + 3);
    chk({tag, " n_writes"}, sa_q.size(), 1);
    if (sa_q.size() > 0) begin
      chk({tag, " addr"}, sa_q[0], 0);
      chk({tag, " data"}, sd_q[0], exp_s());
      chk({tag, " wcyc"}, sc_q[0], s0 + 2);
    end
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    sa_q.delete(); sd_q.delete(); sc_q.delete();
  endtask

  task automatic rand_big();
    for (int n = 0; n < B_IN; n++) b_in[n] = shortint'($urandom);
    for (int o = 0; o < B_OUT; o++)
      for (int n = 0; n < B_IN; n++) b_w[o][n] = shortint'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s2, d, d1, nd;
    logic [DW*PO-1:0] first[$];
    logic [DW*PO-1:0] lit;
    rand_big();

    // reset held low with start asserted
    reset = 1'b0; start_b = 1'b1; start_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst ctrl_b[%0d]", i), {busy_b, done_b, out_wren_b, in_rden_b, w_rden_b}, 0);
      chk($sformatf("rst ctrl_s[%0d]", i), {busy_s, done_s, out_wren_s, in_rden_s, w_rden_s}, 0);
    end
    chk("rst addr_b", {in_addr_b, w_addr_b, out_addr_b}, 0);
    chk("rst data_b", out_data_b, 0);
    chk("rst data_s", {in_addr_s, w_addr_s, out_addr_s, out_data_s}, 0);
    reset = 1'b1; start_b = 1'b0; start_s = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle after rst", {busy_b, busy_s}, 0);

    // identity single-beat pass
    s_in = '{1, 2, 3, 4};
    s_w[0] = '{1, 0, 0, 0};
    s_w[1] = '{0, 0, 0, 1};
    clear_q();
    go(1'b0, s0); wait_done(1'b0, "t2", d); check_pass_s("t2", s0, d);
    chk("t2 literal", sd_q.size() > 0 ? sd_q[0] : 'x, 32'h0004_0001);

    // saturation both directions in one word
    for (int i = 0; i < S_IN; i++) begin s_in[i] = 16'sh7FFF; s_w[0][i] = 16'sh7FFF; s_w[1][i] = -16'sh8000; end
    clear_q();
    go(1'b0, s0); wait_done(1'b0, "t4", d); check_pass_s("t4", s0, d);
`ifdef FC_RELU_EN
    lit = 32'h0000_7FFF;
`else
    lit = 32'h8000_7FFF;
`endif
    chk("t4 literal", sd_q.size() > 0 ? sd_q[0] : 'x, lit);

    for (int i = 0; i < S_IN; i++) begin
      s_in[i] = shortint'($urandom_range(0, 511)) - 16'sd256;
      s_w[0][i] = shortint'($urandom); s_w[1][i] = shortint'($urandom_range(0, 255)) - 16'sd128;
    end
    clear_q();
    go(1'b0, s0); wait_done(1'b0, "t4r", d); check_pass_s("t4r", s0, d);

    // multi-beat constant pass
    for (int n = 0; n < B_IN; n++) b_in[n] = 16'sd256;
    for (int o = 0; o < B_OUT; o++) for (int n = 0; n < B_IN; n++) b_w[o][n] = 16'sd256;
    clear_q();
    go(1'b1, s0); wait_done(1'b1, "t3", d); check_pass_b("t3", s0, d);
    chk("t3 literal", wd_q.size() > 0 ? wd_q[0] : 'x, 32'h4000_4000);

    // start while busy is ignored
    rand_big(); clear_q();
    go(1'b1, s0);
    repeat (30) @(negedge clk);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_done(1'b1, "t5a", d); check_pass_b("t5a", s0, d);
    repeat (5) @(negedge clk);
    chk("t5a quiet writes", wa_q.size(), B_GROUPS);
    chk("t5a quiet busy", busy_b, 0);

    // reset at beat 5 of group 1
    rand_big(); clear_q();
    go(1'b1, s0);
    while (cyc < s0 + 23) @(negedge clk);
    chk("t5b at beat", {out_addr_b, in_addr_b, in_rden_b}, {3'd1, 4'd5, 1'b1});
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    chk("t5b aborted", {busy_b, in_rden_b, w_rden_b, out_wren_b, in_addr_b, w_addr_b, out_addr_b}, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (done_b) nd++; end
    chk("t5b no done", nd, 0);
    chk("t5b one write", wa_q.size(), 1);

    // back-to-back passes, with start also offered during the done cycle
    rand_big(); clear_q();
    go(1'b1, s0); wait_done(1'b1, "t6a", d1); check_pass_b("t6a", s0, d1);
    first = wd_q;
    start_b = 1'b1;
    clear_q();
    @(negedge clk);
    @(posedge clk); #1;
    start_b = 1'b0; s2 = cyc;
    chk("t6 restart cyc", s2, d1 + 2);
    wait_done(1'b1, "t6b", d); check_pass_b("t6b", s2, d);
    for (int g = 0; g < B_GROUPS && g < wd_q.size() && g < first.size(); g++)
      chk($sformatf("t6 same[%0d]", g), wd_q[g], first[g]);
    repeat (4) @(negedge clk);
    chk("t6 end idle", {busy_b, wa_q.size() == B_GROUPS}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
